// File: rtl/xlib_stim.sv
// -----------------------------------------------------------------------------
// xlib_stim -- operand stimulus generator and result checker for an 8-bit adder
// style consumer.
//
// Each run presents N_VECTORS operand pairs drawn from an 8-bit LFSR
// (A = lfsr, B = lfsr >> 1, so A > B always). A pair is held on A/B with
// VALID until the consumer accepts it (VALID & READY). The consumer's result
// on XOUT/XOUT_VALID is compared against (A + B) mod 256. A missing result
// after TIMEOUT wait cycles also counts as an error. ERR_COUNT saturates at 255.
//
// Parameters:
//   N_VECTORS  operand pairs per run (1..255)
//   SEED       initial LFSR value (8'h00 is replaced by 8'h01)
//   TIMEOUT    wait cycles allowed for a result (1..255)
//
// Ports:
//   CLK         clock, all state changes on the rising edge
//   RST         synchronous active-high reset
//   START       run request, honoured only when idle or finished
//   A, B        operand pair
//   VALID       A/B hold a valid pair
//   READY       consumer accepts the pair
//   XOUT        consumer result
//   XOUT_VALID  XOUT valid this cycle (ignored outside the wait phase)
//   BUSY        run in progress
//   DONE        run complete, held until the next START
//   ERR_COUNT   mismatches plus timeouts, saturating
//
// Optional feature: define XLIB_STIM_TRACE_EN to print one trace line per
// checked vector. Cycle behaviour is identical either way.
// -----------------------------------------------------------------------------
module xlib_stim #(
  parameter int          N_VECTORS = 16,
  parameter logic [7:0]  SEED      = 8'h17,
  parameter int          TIMEOUT   = 10
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  output logic [7:0] A,
  output logic [7:0] B,
  output logic       VALID,
  input  logic       READY,
  input  logic [7:0] XOUT,
  input  logic       XOUT_VALID,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] ERR_COUNT
);

  // An all-zero LFSR would lock up, so a zero seed is remapped.
  localparam logic [7:0] SEED_FIX  = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [7:0] N_INIT    = 8'(N_VECTORS);
  // The counter starts at 0, so the last permitted wait cycle is TIMEOUT-1.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_WAIT,
    S_CHECK,
    S_FIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [7:0] remaining_q, remaining_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] exp_q, exp_d;
  logic [7:0] xout_q, xout_d;
  logic       timeout_q, timeout_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] err_q, err_d;

  logic [7:0] lfsr_step;
  logic       mismatch;

  assign lfsr_step = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign mismatch  = (xout_q != exp_q);

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    remaining_d = remaining_q;
    wait_cnt_d  = wait_cnt_q;
    exp_d       = exp_q;
    xout_d      = xout_q;
    timeout_d   = timeout_q;
    a_d         = a_q;
    b_d         = b_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = done_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE, S_FIN: begin
        if (START) begin
          state_d     = S_DRIVE;
          lfsr_d      = SEED_FIX;
          remaining_d = N_INIT;
          err_d       = 8'h00;
          a_d         = SEED_FIX;
          b_d         = {1'b0, SEED_FIX[7:1]};
          valid_d     = 1'b1;
          busy_d      = 1'b1;
          done_d      = 1'b0;
        end
      end

      S_DRIVE: begin
        // A/B/VALID are registers and are not touched until the handshake.
        if (READY) begin
          state_d    = S_WAIT;
          valid_d    = 1'b0;
          wait_cnt_d = 8'h00;
          exp_d      = a_q + b_q;
        end
      end

      S_WAIT: begin
        // A result on the final wait cycle takes precedence over the timeout.
        if (XOUT_VALID) begin
          xout_d    = XOUT;
          timeout_d = 1'b0;
          state_d   = S_CHECK;
        end else if (wait_cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_CHECK;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      S_CHECK: begin
        if ((timeout_q || mismatch) && (err_q != 8'hFF)) begin
          err_d = err_q + 8'd1;
        end
        lfsr_d      = lfsr_step;
        remaining_d = remaining_q - 8'd1;
        if (remaining_q == 8'd1) begin
          state_d = S_FIN;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRIVE;
          a_d     = lfsr_step;
          b_d     = {1'b0, lfsr_step[7:1]};
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED_FIX;
      remaining_q <= 8'h00;
      wait_cnt_q  <= 8'h00;
      exp_q       <= 8'h00;
      xout_q      <= 8'h00;
      timeout_q   <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      remaining_q <= remaining_d;
      wait_cnt_q  <= wait_cnt_d;
      exp_q       <= exp_d;
      xout_q      <= xout_d;
      timeout_q   <= timeout_d;
      a_q         <= a_d;
      b_q         <= b_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef XLIB_STIM_TRACE_EN
  always_ff @(posedge CLK) begin
    if (!RST && state_q == S_CHECK) begin
      $display("TIME=%0t A=%02h B=%02h X=%02h EXP=%02h%s", $time, a_q, b_q, xout_q, exp_q,
               timeout_q ? " TIMEOUT" : (mismatch ? " MISMATCH" : ""));
    end
  end
`endif

  assign A         = a_q;
  assign B         = b_q;
  assign VALID     = valid_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign ERR_COUNT = err_q;

endmodule

// File: tb/tb_xlib_stim.sv
// -----------------------------------------------------------------------------
// Testbench for xlib_stim. The bench plays the consumer, drives directed runs
// and keeps its own expected-operand table and error tally. A negedge monitor
// checks every cycle in which VALID or DONE is high.
// -----------------------------------------------------------------------------
module tb_xlib_stim;

  localparam int NV  = 16;
  localparam int TMO = 10;

  logic       CLK = 1'b0;
  logic       RST, START, READY, XOUT_VALID;
  logic [7:0] XOUT;
  logic [7:0] A, B, ERR_COUNT;
  logic       VALID, BUSY, DONE;
  logic [7:0] A_z, B_z, ERR_COUNT_z;
  logic       VALID_z, BUSY_z, DONE_z;

  int n_vec  = 0;
  int n_fail = 0;
  int exp_err = 0;
  logic [7:0] exp_a [NV];

  always #5 CLK = ~CLK;

  xlib_stim #(.N_VECTORS(NV), .SEED(8'h17), .TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST(RST), .START(START), .A(A), .B(B), .VALID(VALID),
    .READY(READY), .XOUT(XOUT), .XOUT_VALID(XOUT_VALID),
    .BUSY(BUSY), .DONE(DONE), .ERR_COUNT(ERR_COUNT)
  );

  // Zero seed must be remapped to 1.
  xlib_stim #(.N_VECTORS(1), .SEED(8'h00), .TIMEOUT(1)) dut_z (
    .CLK(CLK), .RST(RST), .START(START), .A(A_z), .B(B_z), .VALID(VALID_z),
    .READY(READY), .XOUT(XOUT), .XOUT_VALID(XOUT_VALID),
    .BUSY(BUSY_z), .DONE(DONE_z), .ERR_COUNT(ERR_COUNT_z)
  );

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h required %02h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b at %0t", name, act, req, $time);
    end
  endtask

  // Per-cycle monitor: operand sequence, B derivation, flags, stall stability.
  initial begin
    logic [7:0] v;
    int idx;
    logic prev_hold;
    logic [7:0] prev_a, prev_b;
    v = 8'h17;
    for (int i = 0; i < NV; i++) begin
      exp_a[i] = v;
      v = {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    end
    idx = 0;
    prev_hold = 1'b0;
    prev_a = 8'h00;
    prev_b = 8'h00;
    forever begin
      @(negedge CLK);
      if (prev_hold) begin
        check1("mon_hold_valid", VALID, 1'b1);
        check8("mon_hold_a", A, prev_a);
        check8("mon_hold_b", B, prev_b);
      end
      if (VALID) begin
        if (idx < NV) check8("mon_a_seq", A, exp_a[idx]);
        check8("mon_b_half", B, {1'b0, A[7:1]});
        check1("mon_busy_drive", BUSY, 1'b1);
        check1("mon_done_drive", DONE, 1'b0);
      end
      if (DONE) begin
        check1("mon_busy_done", BUSY, 1'b0);
        check1("mon_valid_done", VALID, 1'b0);
      end
      prev_hold = VALID && !READY && !RST;
      prev_a = A;
      prev_b = B;
      if (RST || (START && !BUSY)) idx = 0;
      else if (VALID && READY) idx++;
    end
  end

  task automatic do_start();
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    exp_err = 0;
    check1("start_busy", BUSY, 1'b1);
    check1("start_valid", VALID, 1'b1);
    check1("start_done", DONE, 1'b0);
    check8("start_err_clear", ERR_COUNT, 8'h00);
  endtask

  // Entered #1 after the edge that put the DUT in DRIVE; leaves #1 after the
  // edge that ends CHECK. resp_cycle 0 means no result (timeout).
  task automatic do_vector(input int idx, input int stall, input int resp_cycle, input bit wrong);
    logic [7:0] a_s, b_s;
    check1("drv_valid", VALID, 1'b1);
    check8("drv_a", A, exp_a[idx]);
    a_s = A;
    b_s = B;
    READY = 1'b0;
    for (int i = 0; i < stall; i++) begin
      // Stray result and START while busy must both be ignored.
      XOUT_VALID = 1'b1;
      XOUT = 8'h00;
      START = 1'b1;
      @(posedge CLK); #1;
      check1("stall_valid", VALID, 1'b1);
      check8("stall_a", A, a_s);
      check8("stall_b", B, b_s);
    end
    XOUT_VALID = 1'b0;
    START = 1'b0;
    READY = 1'b1;
    @(posedge CLK); #1;
    READY = 1'b0;
    check1("wait_valid_low", VALID, 1'b0);
    check1("wait_busy", BUSY, 1'b1);
    if (resp_cycle == 0) begin
      repeat (TMO) @(posedge CLK);
      #1;
      exp_err++;
    end else begin
      for (int i = 1; i < resp_cycle; i++) begin
        @(posedge CLK); #1;
      end
      XOUT_VALID = 1'b1;
      XOUT = 8'(a_s + b_s + (wrong ? 8'd1 : 8'd0));
      @(posedge CLK); #1;
      XOUT_VALID = 1'b0;
      if (wrong) exp_err++;
    end
    check1("chk_busy", BUSY, 1'b1);
    check1("chk_valid", VALID, 1'b0);
    @(posedge CLK); #1;
    check8("err_after_vec", ERR_COUNT, 8'(exp_err));
    if (idx == NV - 1) begin
      check1("fin_done", DONE, 1'b1);
      check1("fin_busy", BUSY, 1'b0);
    end else begin
      check1("next_valid", VALID, 1'b1);
    end
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    READY = 1'b0;
    XOUT = 8'h00;
    XOUT_VALID = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check8("rst_a", A, 8'h00);
    check8("rst_b", B, 8'h00);
    check1("rst_valid", VALID, 1'b0);
    check1("rst_busy", BUSY, 1'b0);
    check1("rst_done", DONE, 1'b0);
    check8("rst_err", ERR_COUNT, 8'h00);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Run 1: correct consumer, minimum latency.
    do_start();
    check8("seed_z_a", A_z, 8'h01);
    check8("seed_z_b", B_z, 8'h00);
    check8("first_a", A, 8'h17);
    check8("first_b", B, 8'h0B);
    for (int i = 0; i < NV; i++) begin
      do_vector(i, 0, 1, 1'b0);
      if (i == 0) begin
        check8("second_a", A, 8'h2F);
        check8("second_b", B, 8'h17);
      end
      if (i == 1) check8("third_a", A, 8'h5E);
    end
    check8("run1_err", ERR_COUNT, 8'h00);
    repeat (3) @(posedge CLK);
    #1;
    check1("done_held", DONE, 1'b1);
    check1("busy_held_low", BUSY, 1'b0);

    // Run 2: wrong result on vector 3, stall on vector 5, late result on 6.
    do_start();
    for (int i = 0; i < NV; i++) begin
      do_vector(i, (i == 4) ? 5 : 0, (i == 5) ? TMO : 1, i == 2);
    end
    check8("run2_err", ERR_COUNT, 8'h01);

    // Run 3: timeout on vector 1, reset in WAIT of vector 4.
    do_start();
    do_vector(0, 0, 0, 1'b0);
    check8("timeout_err", ERR_COUNT, 8'h01);
    do_vector(1, 0, 1, 1'b0);
    do_vector(2, 0, 1, 1'b0);
    check8("fourth_a", A, 8'hBC);
    READY = 1'b1;
    @(posedge CLK); #1;
    READY = 1'b0;
    check1("v4_in_wait", VALID, 1'b0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check8("midrst_a", A, 8'h00);
    check8("midrst_b", B, 8'h00);
    check1("midrst_valid", VALID, 1'b0);
    check1("midrst_busy", BUSY, 1'b0);
    check1("midrst_done", DONE, 1'b0);
    check8("midrst_err", ERR_COUNT, 8'h00);
    START = 1'b1;
    @(posedge CLK); #1;
    check1("rst_over_start_busy", BUSY, 1'b0);
    check1("rst_over_start_valid", VALID, 1'b0);
    RST = 1'b0;
    START = 1'b0;
    @(posedge CLK); #1;
    do_start();
    check8("restart_a", A, 8'h17);
    check8("restart_b", B, 8'h0B);
    for (int i = 0; i < NV; i++) begin
      do_vector(i, 0, 1, 1'b0);
    end
    check8("run3_err", ERR_COUNT, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/xlib_stim.md
XLIB_STIM -- requirements
Module: xlib_stim

Interface
REQ-001 Parameter N_VECTORS, default 16, number of operand pairs per run (1..255).
REQ-002 Parameter SEED, default 8'h17, initial LFSR value; 8'h00 SHALL be replaced by 8'h01.
REQ-003 Parameter TIMEOUT, default 10, maximum cycles to wait for a result (1..255).
REQ-004 CLK  in  1  single clock; all state changes on its rising edge.
REQ-005 RST  in  1  reset, synchronous and active-high.
REQ-006 START  in  1  run request; sampled only in IDLE or DONE.
REQ-007 A  out  8  operand A, unsigned.
REQ-008 B  out  8  operand B, unsigned.
REQ-009 VALID  out  1  A/B hold a valid operand pair.
REQ-010 READY  in  1  consumer accepts the pair; transfer occurs on an edge where VALID and READY are both 1.
REQ-011 XOUT  in  8  consumer result, unsigned.
REQ-012 XOUT_VALID  in  1  XOUT is valid this cycle.
REQ-013 BUSY  out  1  run in progress.
REQ-014 DONE  out  1  run complete.
REQ-015 ERR_COUNT  out  8  mismatches plus timeouts, saturating at 255.

Function
REQ-016 The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK and FIN.
REQ-017 IDLE/FIN with START=1: load the LFSR from SEED, set remaining to N_VECTORS, clear ERR_COUNT, go to DRIVE.
REQ-018 DRIVE: A = lfsr; B = {1'b0, lfsr[7:1]}, which guarantees A > B; VALID = 1.
REQ-019 DRIVE: A, B and VALID SHALL stay stable until the VALID&READY edge, then go to WAIT with VALID = 0 on the next cycle.
REQ-020 WAIT: latch the expected value = (A + B) mod 256; the wait counter counts cycles from 0.
REQ-021 WAIT with XOUT_VALID=1: capture XOUT and go to CHECK.
REQ-022 WAIT timeout: if the counter reaches TIMEOUT without XOUT_VALID, go to CHECK flagged as error.
REQ-023 If XOUT_VALID coincides with the timeout cycle, the result SHALL win over the timeout.
REQ-024 CHECK (one cycle): increment ERR_COUNT (saturating) if there was a timeout or XOUT != expected.
REQ-025 CHECK, LFSR advance: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
REQ-026 CHECK, remaining decrements; if the result is 0 go to FIN, else go to DRIVE.
REQ-027 FIN: DONE = 1 and BUSY = 0, both held until the next START.
REQ-028 BUSY = 1 in DRIVE, WAIT and CHECK.
REQ-029 START SHALL be ignored while BUSY = 1.
REQ-030 XOUT_VALID outside WAIT SHALL be ignored.
REQ-031 Minimum latency per vector with READY=1 and an immediate result: 3 cycles (DRIVE, WAIT, CHECK).

Reset
REQ-032 RST=1 SHALL force IDLE from any state, including mid-run, on the next edge.
REQ-033 Output values under RST: A=0, B=0, VALID=0, BUSY=0, DONE=0, ERR_COUNT=0.
REQ-034 Internal values under RST: LFSR = SEED (0 mapped to 1), remaining = 0, wait counter = 0.
REQ-035 RST SHALL take priority over START on the same edge.

Configuration
REQ-036 Macro XLIB_STIM_TRACE_EN defined: each CHECK SHALL $display "TIME=<t> A=<a> B=<b> X=<xout> EXP=<exp>" plus " TIMEOUT" or " MISMATCH" when applicable.
REQ-037 Macro XLIB_STIM_TRACE_EN undefined: no display code is compiled and cycle behaviour is identical.

Verification
REQ-038 SEED=8'h17, READY=1, consumer returns A+B one cycle after the transfer -> first pair A=8'h17, B=8'h0B; XOUT=8'h22 accepted; second pair A=8'h2F, B=8'h17.
REQ-039 N_VECTORS=16 with a correct consumer -> DONE=1 after the 16th CHECK, ERR_COUNT=0, BUSY=0.
REQ-040 Consumer returns A+B+1 on vector 3 only -> ERR_COUNT=1 at DONE.
REQ-041 READY held 0 for 5 cycles -> A/B/VALID stable for all 5 cycles, transfer on the first READY=1 edge.
REQ-042 TIMEOUT=10 with no XOUT_VALID -> CHECK entered after 10 WAIT cycles, ERR_COUNT increments, next vector driven; XOUT_VALID on cycle 10 -> no timeout error counted.
REQ-043 RST asserted in WAIT during vector 4 -> next cycle IDLE with all outputs 0; START then restarts with A=8'h17.
